// File: rtl/ysyx_040750_ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op one-hot bit
// positions, FSM state encoding and iteration counts.
package ysyx_040750_ex_muldiv_pkg;

  localparam int OP_MUL  = 0;
  localparam int OP_MULH = 1;
  localparam int OP_DIV  = 2;
  localparam int OP_REM  = 3;

  localparam int ITER_D = 64;
  localparam int ITER_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/ysyx_040750_ex_muldiv.sv
// Iterative radix-2 multiply / restoring divide sharing one shift datapath.
// Result valid 65 edges after start (33 for word ops); held in DONE until I_allowout.
module ysyx_040750_ex_muldiv
  import ysyx_040750_ex_muldiv_pkg::*;
(
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_start,
  input  logic [3:0]  I_op,
  input  logic [1:0]  I_sext,
  input  logic        I_word_op,
  input  logic [63:0] I_op1,
  input  logic [63:0] I_op2,
  input  logic        I_allowout,
  input  logic        I_flush,
  output logic [63:0] O_result,
  output logic        O_valid,
  output logic        O_busy
);

  state_e       state_q;
  logic [6:0]   cnt_q;
  logic [127:0] acc_q;
  logic [63:0]  sh_q;
  logic [63:0]  opb_q;
  logic [3:0]   op_q;
  logic         word_q;
  logic         is_mul_q;
  logic         neg_res_q;
  logic         neg1_q;
  logic         div0_q;
  logic [63:0]  result_q;
  logic         valid_q;

  // Operand preparation: word extension, then signed magnitudes.
  logic [63:0] op1_x, op2_x, a_mag, b_mag, sh_init, opb_init;
  logic        n1, n2, is_mul_in;

  always_comb begin
    op1_x     = I_word_op ? {{32{I_sext[0] & I_op1[31]}}, I_op1[31:0]} : I_op1;
    op2_x     = I_word_op ? {{32{I_sext[1] & I_op2[31]}}, I_op2[31:0]} : I_op2;
    n1        = I_sext[0] & op1_x[63];
    n2        = I_sext[1] & op2_x[63];
    a_mag     = cond_neg(op1_x, n1);
    b_mag     = cond_neg(op2_x, n2);
    is_mul_in = I_op[OP_MUL] | I_op[OP_MULH];
    sh_init   = is_mul_in ? b_mag : a_mag;
    if (I_word_op) sh_init = {sh_init[31:0], 32'd0};
    opb_init  = is_mul_in ? a_mag : b_mag;
  end

  // One iteration: MSB-first shift-add, or restoring shift-subtract.
  logic [127:0] acc_d;
  logic [63:0]  sh_d, diff;
  logic [64:0]  rem_sh;
  logic         ge;

  always_comb begin
    rem_sh = {acc_q[63:0], sh_q[63]};
    ge     = rem_sh >= {1'b0, opb_q};
    diff   = rem_sh[63:0] - opb_q;
    if (is_mul_q) begin
      acc_d = {acc_q[126:0], 1'b0} + (sh_q[63] ? {64'd0, opb_q} : 128'd0);
      sh_d  = {sh_q[62:0], 1'b0};
    end else begin
      acc_d = {64'd0, ge ? diff : rem_sh[63:0]};
      sh_d  = {sh_q[62:0], ge};
    end
  end

  // Final sign correction and result selection.
  logic [127:0] prod_s;
  logic [63:0]  quo, rem, raw, result_d;

  always_comb begin
    prod_s = neg_res_q ? (~acc_q + 128'd1) : acc_q;
    quo    = div0_q ? {64{1'b1}} : cond_neg(sh_q, neg_res_q);
    rem    = cond_neg(acc_q[63:0], neg1_q);
    raw    = prod_s[63:0];
    if (op_q[OP_MULH]) raw = word_q ? {32'd0, prod_s[63:32]} : prod_s[127:64];
    if (op_q[OP_DIV])  raw = quo;
    if (op_q[OP_REM])  raw = rem;
    result_d = word_q ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

  logic [6:0] last_cnt;
  logic       accept;

  assign last_cnt = word_q ? 7'(ITER_W) : 7'(ITER_D);
  assign accept   = I_start & ((state_q == S_IDLE) | ((state_q == S_DONE) & I_allowout));

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      is_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg1_q    <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (I_flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          if (cnt_q == last_cnt) begin
            result_q <= result_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_DONE: begin
          if (I_allowout) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A new request overrides the DONE->IDLE exit (back-to-back issue).
      if (accept) begin
        state_q   <= S_CALC;
        cnt_q     <= '0;
        valid_q   <= 1'b0;
        acc_q     <= '0;
        sh_q      <= sh_init;
        opb_q     <= opb_init;
        op_q      <= I_op;
        word_q    <= I_word_op;
        is_mul_q  <= is_mul_in;
        neg_res_q <= n1 ^ n2;
        neg1_q    <= n1;
        div0_q    <= (b_mag == 64'd0);
      end
    end
  end

  assign O_result = result_q;
  assign O_valid  = valid_q;
  assign O_busy   = (state_q != S_IDLE);

endmodule

// File: doc/ysyx_040750_ex_muldiv.md
YSYX_040750_EX_MULDIV -- requirements
Module: ysyx_040750_EX_muldiv

Interface
REQ-001 SHALL provide port I_sys_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL provide port I_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port I_start, input, 1, one-cycle request pulse from the ID/EX register's multicycle flag.
REQ-004 SHALL provide port I_op, input, 4, one-hot operation: bit0 MUL (low 64), bit1 MULH (high 64), bit2 DIV, bit3 REM.
REQ-005 SHALL provide port I_sext, input, 2, signedness: bit0 op1 signed, bit1 op2 signed.
REQ-006 SHALL provide port I_word_op, input, 1, 32-bit word operation.
REQ-007 SHALL provide ports I_op1 and I_op2, input, 64, operands.
REQ-008 SHALL provide port I_allowout, input, 1, downstream (EX/MEM) accepts the result.
REQ-009 SHALL provide port I_flush, input, 1, abort the current operation.
REQ-010 SHALL provide port O_result, output, 64, final result.
REQ-011 SHALL provide port O_valid, output, 1, result valid; this is the EX stage alu-output-valid signal.
REQ-012 SHALL provide port O_busy, output, 1, operation in progress, DONE included.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE with I_start=1, latch operands, op, sext and word flag, and enter CALC with iteration counter 0.
REQ-015 SHALL, before CALC, convert signed operands to magnitudes and record the result sign.
REQ-016 SHALL perform one radix-2 shift-add (MUL/MULH) or restoring shift-subtract (DIV/REM) iteration per CALC cycle.
REQ-017 SHALL run 64 iterations, or 32 when I_word_op=1, then enter DONE.
REQ-018 SHALL set the DONE cycle count: O_valid rises 65 edges after the start edge (33 for word ops).
REQ-019 SHALL, in DONE, hold O_valid=1 and O_result stable until a cycle with I_allowout=1, then go to IDLE.
REQ-020 SHALL, when DONE, I_allowout=1 and I_start=1 coincide, accept the new request and enter CALC directly (back-to-back).
REQ-021 SHALL ignore I_start in CALC.
REQ-022 SHALL apply sign correction to the result in DONE: negate quotient if the operand signs differ; the remainder takes the dividend sign.
REQ-023 SHALL, on divide by zero, return quotient all-ones and remainder equal to the dividend.
REQ-024 SHALL, on signed overflow (most-negative / -1), return quotient equal to the dividend and remainder 0.
REQ-025 SHALL, for word ops, compute on the low 32 operand bits and sign-extend result bit 31 into bits 63:32.
REQ-026 SHALL return to IDLE on I_flush=1 in any state, clearing O_valid the next cycle; flush wins over a simultaneous start.
REQ-027 SHALL produce a 128-bit product internally; MULH returns bits 127:64 with correct signed/unsigned mix.

Reset
REQ-028 SHALL, on I_rst_n=0, immediately force IDLE, O_valid=0, O_busy=0, O_result=0 and counter 0, independent of the clock.
REQ-029 SHALL, on reset mid-operation, discard the operation with no result produced.

Structure
REQ-030 SHALL place op one-hot bit indices, state encodings and iteration counts (64/32) in the shared ysyx_040750 constants package.
REQ-031 SHALL be a single module with no sub-module; multiply and divide share the accumulator/shift datapath.

Verification
REQ-032 SHALL cover: MUL unsigned 0xFFFFFFFFFFFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE, O_valid 65 edges after start.
REQ-033 SHALL cover: MULH signed (-1)*(-1) -> 0; MULH unsigned 2^63*4 -> 2.
REQ-034 SHALL cover: DIV signed -7/2 -> 0xFFFFFFFFFFFFFFFD; REM -> 0xFFFFFFFFFFFFFFFF; DIV x/0 -> all-ones; REM 5/0 -> 5.
REQ-035 SHALL cover: word DIV 0x80000000/-1 -> 0xFFFFFFFF80000000 after 33 edges.
REQ-036 SHALL cover: hold I_allowout=0 for 10 cycles in DONE -> result stable; flush at iteration 20 -> IDLE, no O_valid.
REQ-037 SHALL cover: deassert I_rst_n mid-CALC -> outputs 0 immediately.
